// File: rtl/mc68030_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc68030_slave_ctrl
// Purpose  : 68030 PDS slave bus-cycle sequencer; decodes the card window,
//            issues one backend request per cycle, ends it with STERM or BERR.
// Revision : 1.0 - initial release
// ============================================================================
module mc68030_slave_ctrl #(
  parameter logic [7:0] SLOT_BASE = 8'hF9,
  parameter int         TIMEOUT   = 255
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        as_n,
  input  logic        ds_n,
  input  logic        rw_n,
  input  logic [1:0]  siz,
  input  logic [2:0]  fc,
  input  logic [31:0] a,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        d_oe,
  output logic        sterm_n,
  output logic        berr_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [29:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WDATA   = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT    = 3'd3,
    S_TERM    = 3'd4,
    S_RECOVER = 3'd5,
    S_BERR    = 3'd6
  } state_t;

  state_t             r_state, w_state;
  logic [29:0]        r_addr, w_addr;
  logic               r_rw_n, w_rw_n;
  logic [3:0]         r_be, w_be_q;
  logic               r_we, w_we;
  logic [31:0]        r_wdata, w_wdata;
  logic [31:0]        r_dout, w_dout;
  logic               r_doe, w_doe;
  logic               r_sterm_n, w_sterm_n;
  logic               r_berr_n, w_berr_n;
  logic               r_req_valid, w_req_valid;
  logic [c_CNT_W-1:0] r_cnt, w_cnt;
  logic               r_abort, w_abort;

  logic       w_claim;
  logic       w_to;
  logic       w_aborted;
  logic       w_rsp_take;
  logic       w_to_fire;
  logic [2:0] w_last_lane;
  logic [3:0] w_be;

  assign w_claim   = !as_n && (a[31:24] == SLOT_BASE) && (fc != 3'b111);
  assign w_to      = (r_cnt == c_TO_LAST);
  assign w_aborted = r_abort | as_n;

  // Lanes past 3 are dropped: the 32-bit port only takes what fits.
  assign w_last_lane = {1'b0, a[1:0]} + ((siz == 2'b00) ? 3'd4 : {1'b0, siz}) - 3'd1;

  always_comb begin
    w_be = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      if ((3'(l) >= {1'b0, a[1:0]}) && (3'(l) <= w_last_lane)) begin
        w_be[2'(3 - l)] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_rw_n      = r_rw_n;
    w_be_q      = r_be;
    w_we        = r_we;
    w_wdata     = r_wdata;
    w_dout      = r_dout;
    w_doe       = r_doe;
    w_sterm_n   = 1'b1;
    w_berr_n    = r_berr_n;
    w_req_valid = 1'b0;
    w_cnt       = r_cnt;
    w_abort     = r_abort;
    w_rsp_take  = 1'b0;
    w_to_fire   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_doe    = 1'b0;
        w_berr_n = 1'b1;
        if (w_claim) begin
          w_addr  = a[31:2];
          w_rw_n  = rw_n;
          w_be_q  = w_be;
          w_we    = ~rw_n;
          w_cnt   = '0;
          w_abort = 1'b0;
          w_state = rw_n ? S_REQ : S_WDATA;
        end
      end
      S_WDATA: begin
        if (as_n) begin
          w_state = S_IDLE;
        end else if (!ds_n) begin
          w_wdata = d_in;
          w_cnt   = '0;
          w_state = S_REQ;
        end
      end
      S_REQ: begin
        w_cnt       = r_cnt + c_CNT_W'(1);
        w_abort     = w_aborted;
        w_req_valid = 1'b1;
        if (r_req_valid && req_ready) begin
          w_req_valid = 1'b0;
          if (rsp_valid) begin
            w_rsp_take = 1'b1;
          end else if (w_to) begin
            w_to_fire = 1'b1;
          end else begin
            w_state = S_WAIT;
          end
        end else if (w_to) begin
          w_req_valid = 1'b0;
          w_to_fire   = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt   = r_cnt + c_CNT_W'(1);
        w_abort = w_aborted;
        if (rsp_valid) begin
          w_rsp_take = 1'b1;
        end else if (w_to) begin
          w_to_fire = 1'b1;
        end
      end
      S_TERM: begin
        w_sterm_n = 1'b0;
        w_doe     = r_rw_n;
        w_state   = S_RECOVER;
      end
      S_RECOVER: begin
        if (as_n) begin
          w_doe   = 1'b0;
          w_state = S_IDLE;
        end
      end
      S_BERR: begin
        if (as_n) begin
          w_berr_n = 1'b1;
          w_state  = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // An aborted cycle still finishes the backend handshake, but the CPU sees nothing.
    if (w_rsp_take) begin
      if (w_aborted) begin
        w_state = S_IDLE;
      end else begin
        if (r_rw_n) begin
          w_dout = rsp_rdata;
        end
        w_state = S_TERM;
      end
    end
    if (w_to_fire) begin
      if (w_aborted) begin
        w_state = S_IDLE;
      end else begin
        w_berr_n = 1'b0;
        w_state  = S_BERR;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rw_n      <= 1'b1;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_dout      <= '0;
      r_doe       <= 1'b0;
      r_sterm_n   <= 1'b1;
      r_berr_n    <= 1'b1;
      r_req_valid <= 1'b0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_rw_n      <= w_rw_n;
      r_be        <= w_be_q;
      r_we        <= w_we;
      r_wdata     <= w_wdata;
      r_dout      <= w_dout;
      r_doe       <= w_doe;
      r_sterm_n   <= w_sterm_n;
      r_berr_n    <= w_berr_n;
      r_req_valid <= w_req_valid;
      r_cnt       <= w_cnt;
      r_abort     <= w_abort;
    end
  end

  assign d_out     = r_dout;
  assign d_oe      = r_doe;
  assign sterm_n   = r_sterm_n;
  assign berr_n    = r_berr_n;
  assign req_valid = r_req_valid;
  assign req_we    = r_we;
  assign req_addr  = r_addr;
  assign req_wdata = r_wdata;
  assign req_be    = r_be;

endmodule
`default_nettype wire

// File: doc/mc68030_slave_ctrl.md
Name: mc68030_slave_ctrl

Overview:
- Slave-side bus-cycle sequencer for the 68030 PDS interface on the ztex213 card.
- Decodes the card's address window and issues one request per CPU cycle to a backend memory/register port.
- Terminates the cycle with STERM for a synchronous 32-bit port, or with BERR on timeout.
- Sits between the PDS pad logic (strobes already registered into cpu_clk) and the internal memory/CSR fabric.

Parameters:
- SLOT_BASE, 8'hF9, value that A[31:24] must match for the card to claim a cycle.
- TIMEOUT, 255, cpu_clk cycles without a backend response before a bus error is signalled.

Ports:
- cpu_clk  in  1  PDS CPU clock; every output and state element is registered on its rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- as_n  in  1  address strobe, registered.
- ds_n  in  1  data strobe, registered.
- rw_n  in  1  1 = read, 0 = write.
- siz  in  2  transfer size: 00 = 4 bytes, 01 = 1, 10 = 2, 11 = 3.
- fc  in  3  function code.
- a  in  32  address.
- d_in  in  32  write data from the bus.
- d_out  out  32  read data to the bus.
- d_oe  out  1  drive enable for D.
- sterm_n  out  1  synchronous termination.
- berr_n  out  1  bus error.
- req_valid  out  1  backend request valid.
- req_ready  in  1  backend accepts the request.
- req_we  out  1  write request.
- req_addr  out  30  longword address, a[31:2].
- req_wdata  out  32  write data.
- req_be  out  4  byte enables; be[3] is D[31:24].
- rsp_valid  in  1  backend response or write-complete strobe.
- rsp_rdata  in  32  read data.

Behaviour:
- Reset values: sterm_n = 1, berr_n = 1, d_oe = 0, d_out = 0, req_valid = 0, req_we = 0, req_addr = 0, req_wdata = 0, req_be = 0. State = IDLE, timeout counter = 0.
- Reset mid-cycle: outputs return to the reset values on the next edge. Any later rsp_valid is ignored until a new request is issued.
- Claim condition: as_n = 0, a[31:24] = SLOT_BASE and fc != 3'b111. CPU-space cycles (fc = 7) and out-of-window addresses are never claimed; all outputs stay deasserted.
- IDLE: when the claim condition holds, latch a, rw_n and siz.
  - Read: go to REQ.
  - Write: go to WDATA.
- WDATA: wait until ds_n = 0, latch d_in into req_wdata, go to REQ. If as_n rises first, go to IDLE with no request.
- REQ: drive req_valid = 1 with req_we = ~rw_n, req_addr and req_be. Hold the request stable until req_ready = 1 is seen on an edge, then drop req_valid and go to WAIT.
- WAIT: on rsp_valid, capture rsp_rdata (reads only) into d_out and go to TERM.
- TERM: sterm_n = 0 for exactly one cycle.
  - Read: d_oe = 1 from this cycle until as_n is sampled high.
  - Go to RECOVER.
- RECOVER: when as_n is sampled high, set d_oe = 0 and sterm_n = 1, go to IDLE. The next claim is accepted no earlier than the following edge.
- Timeout:
  - The counter clears on entry to REQ and counts every cycle in REQ and WAIT.
  - When it reaches TIMEOUT: drop req_valid, set berr_n = 0 and hold it until as_n is sampled high, then go to IDLE. Sterm_n is never asserted in this case.
  - If rsp_valid arrives on the same edge as the timeout, rsp_valid wins (normal TERM).
- Latency: the minimum read is claim edge (N), req_valid at N+1, then req_ready and rsp_valid in the same cycle, which places sterm_n low at N+3.
- Byte enables: offset o = a[1:0], count n = siz (00 means 4). Active lanes are o through min(o+n-1, 3); lane L maps to be[3-L]. Lanes beyond 3 are not enabled, because the 32-bit port takes only what fits.
- If as_n rises during REQ or WAIT (aborted cycle): complete the backend handshake, discard the response, suppress sterm_n, go to IDLE.

Test Plan:
- Longword write 32'h87654321 to F9000000, siz = 00: req_we = 1, req_addr = 30'h3E400000, req_be = 1111, wdata 87654321; sterm_n low for exactly 1 cycle.
- Longword read from F9000004 with the backend returning 789ABCDE: d_out = 789ABCDE, d_oe high from the TERM cycle until as_n high, sterm_n pulse 1 cycle. Verify minimum latency N+3 with zero-wait-state readiness.
- Sizing cases:
  - siz = 01, a[1:0] = 2 gives be 0010.
  - siz = 11, a[1:0] = 1 gives be 0111.
  - siz = 10, a[1:0] = 3 gives be 0001.
  - siz = 00, a[1:0] = 2 gives be 0011.
- Address 50000000, or fc = 7 at F9000000: req_valid, sterm_n, berr_n and d_oe all remain inactive for the whole strobe.
- Backend never asserts rsp_valid: berr_n = 0 exactly TIMEOUT cycles after REQ entry, held until as_n high, sterm_n never low.
- cpu_rst pulsed during WAIT: all outputs reach their reset values on the next edge. A late rsp_valid produces no sterm_n, and the next write completes normally.
